bullet_ctrl: RTL and testbench
==============================

// Module: bullet_ctrl
// PURPOSE
//  Owns one tank bullet: launch, per-frame motion, raster-time hit detection against map flags, and bullet pixels.
//  Drives bullet_collide_o so map_rgb erodes the destroyable tile under the raster.
//  Sits beside map_rgb in the display path and shares its hpos/vpos timing.
// PARAMETERS
//  COLOR_BITS      24         total RGB width; each channel is COLOR_BITS/3
//  BULLET_SIZE     4          bullet square edge, pixels
//  SPEED           2          pixels moved per frame
//  BULLET_COLOR    24'hFFFFFF {blue,green,red} drawn inside the bullet box
//  COOLDOWN_FRAMES 30         frames of refire lockout (only with BULLET_COOLDOWN_EN)
// PORTS
//  clk_i                 in   1   pixel clock
//  rst_ni                in   1   reset, synchronous, active-low
//  frame_start_i         in   1   1-clk pulse at hpos=0, vpos=0
//  display_enable_i      in   1   raster in visible area
//  hpos_i                in   10  raster x
//  vpos_i                in   10  raster y
//  fire_i                in   1   fire button level
//  tank_x_i              in   10  launch x (bullet box top-left)
//  tank_y_i              in   10  launch y
//  tank_dir_i            in   2   0 up, 1 right, 2 down, 3 left
//  all_hard_block_i      in   1   from map_rgb: brick, wall or border at raster
//  destroyable_block_i   in   1   from map_rgb: brick with nonzero state at raster
//  bullet_collide_o      out  1   1-clk pulse on the tile to erode
//  bullet_active_o       out  1   state != IDLE
//  bullet_enable_o       out  1   raster inside box, state FLY
//  bullet_red_o          out  C/3 BULLET_COLOR red when bullet_enable_o, else 0
//  bullet_green_o        out  C/3 same rule, green
//  bullet_blue_o         out  C/3 same rule, blue
// BEHAVIOUR
//  - Reset: state IDLE; bx=by=0; dir=0; hit, hit_d cleared; every output 0.
//  - in_box = display_enable_i && hpos in [bx, bx+BULLET_SIZE-1] && vpos in [by, by+BULLET_SIZE-1]. Compares are unsigned 10-bit.
//  - IDLE: a rising edge of fire_i loads bx, by, dir from the tank_* inputs and moves to FLY next clk. A held fire_i does not refire.
//  - FLY, each clk: if in_box && all_hard_block_i, set hit. If destroyable_block_i is also high, set hit_d.
//  - FLY, on frame_start_i:
//    - hit set -> REPORT; position frozen.
//    - else step SPEED along dir.
//    - A step that would go below 0, or put bx or by above 1023-BULLET_SIZE, -> IDLE with no pulse.
//  - REPORT, first clk of the frame with in_box && destroyable_block_i && hit_d: bullet_collide_o=1 for exactly that clk. At most one pulse per REPORT.
//  - REPORT, on the next frame_start_i -> IDLE; clear hit and hit_d.
//  - Wall or border hit (hit_d=0): REPORT lasts one frame with no pulse.
//  - frame_start_i and a hit sample in the same clk: the hit is recorded first, so the bullet goes to REPORT.
//  - fire_i is ignored outside IDLE. rst_ni low mid-flight forces IDLE next clk and kills any pending pulse.
//  - Colour outputs are combinational from state and registered bx/by, with zero added latency vs hpos/vpos.
// CONFIGURATION
//  - `BULLET_COOLDOWN_EN defined: REPORT->IDLE and out-of-bounds->IDLE load a frame counter with COOLDOWN_FRAMES.
//    The counter decrements on each frame_start_i. A fire edge is accepted only when the counter is 0. Reset clears it.
//  - `BULLET_COOLDOWN_EN undefined: no counter; a fire edge is accepted on any IDLE clk.
// STRUCTURE
//  - tank_pkg: dir_e (UP, RIGHT, DOWN, LEFT), bullet_state_e (IDLE, FLY, REPORT), block-type constants shared with map_rgb.
//  - Sub-module: pos_edge_detect instance on fire_i (existing block).
// TESTING
//  1. Fire edge at tank (100,200), dir RIGHT, open air -> FLY. After 3 frame_start_i, bx=106, by=200. Pixels drawn only in [106..109]x[200..203].
//  2. Bullet overlaps a 1111 brick -> REPORT next frame. One bullet_collide_o pulse at the first in-box brick pixel, then IDLE.
//  3. Bullet hits a WALL (all_hard=1, destroyable=0) -> REPORT with no pulse, then IDLE.
//  4. Bullet going LEFT with bx=1 -> IDLE at next frame_start_i with no pulse. fire_i held high throughout -> no relaunch.
//  5. rst_ni=0 for 1 clk during REPORT, before the pulse -> outputs 0 next clk. No pulse that frame.
//  6. With BULLET_COOLDOWN_EN: fire edges at 10 and at 29 frames after IDLE are ignored. A fire edge at 30 frames launches.

Source files
------------

// File: rtl/tank_pkg.sv
// -----------------------------------------------------------------------------
// tank_pkg
//  Types and constants shared by the tank game blocks (bullet_ctrl, map_rgb).
//  dir_e          : travel direction encoding used on tank_dir_i
//  bullet_state_e : bullet life cycle
//  BLK_*          : map tile type codes, matching the map_rgb tile memory
// -----------------------------------------------------------------------------
package tank_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLY    = 2'd1,
    REPORT = 2'd2
  } bullet_state_e;

  localparam logic [1:0] BLK_EMPTY  = 2'd0;
  localparam logic [1:0] BLK_BRICK  = 2'd1;
  localparam logic [1:0] BLK_WALL   = 2'd2;
  localparam logic [1:0] BLK_BORDER = 2'd3;

  // A tile stops a bullet when it is anything other than empty floor.
  function automatic logic is_hard_block(input logic [1:0] blk);
    return (blk == BLK_BRICK) || (blk == BLK_WALL) || (blk == BLK_BORDER);
  endfunction

endpackage

// File: rtl/pos_edge_detect.sv
// -----------------------------------------------------------------------------
// pos_edge_detect
//  One-clock pulse on a rising edge of a level input.
//  clk_i  : clock
//  rst_ni : synchronous active-low reset (history cleared to 0)
//  sig_i  : level input
//  edge_o : sig_i high now and low on the previous clock
// -----------------------------------------------------------------------------
module pos_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic edge_o
);

  logic sig_q;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) sig_q <= 1'b0;
    else         sig_q <= sig_i;
  end

  assign edge_o = sig_i & ~sig_q;

endmodule

// File: rtl/bullet_ctrl.sv
// -----------------------------------------------------------------------------
// bullet_ctrl
//  Owns one tank bullet: launch on a fire edge, per-frame motion, raster-time
//  hit detection against map flags, bullet pixels and the erode pulse for
//  map_rgb. Shares hpos/vpos timing with map_rgb.
//
//  Optional feature: define BULLET_COOLDOWN_EN to lock out refire for
//  COOLDOWN_FRAMES frames after the bullet returns to IDLE.
//
//  Ports
//   clk_i, rst_ni            pixel clock, synchronous active-low reset
//   frame_start_i            1-clk pulse at hpos=0, vpos=0
//   display_enable_i         raster in visible area
//   hpos_i, vpos_i           raster position
//   fire_i                   fire button level
//   tank_x_i/y_i/dir_i       launch box top-left and direction
//   all_hard_block_i         raster tile is brick, wall or border
//   destroyable_block_i      raster tile is a brick with nonzero state
//   bullet_collide_o         1-clk pulse on the tile to erode
//   bullet_active_o          bullet not IDLE
//   bullet_enable_o          raster inside flying bullet box
//   bullet_red/green/blue_o  bullet colour when bullet_enable_o, else 0
// -----------------------------------------------------------------------------
module bullet_ctrl
  import tank_pkg::*;
#(
  parameter int                    COLOR_BITS      = 24,
  parameter int                    BULLET_SIZE     = 4,
  parameter int                    SPEED           = 2,
  parameter logic [COLOR_BITS-1:0] BULLET_COLOR    = 24'hFFFFFF,
  parameter int                    COOLDOWN_FRAMES = 30
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    frame_start_i,
  input  logic                    display_enable_i,
  input  logic [9:0]              hpos_i,
  input  logic [9:0]              vpos_i,
  input  logic                    fire_i,
  input  logic [9:0]              tank_x_i,
  input  logic [9:0]              tank_y_i,
  input  logic [1:0]              tank_dir_i,
  input  logic                    all_hard_block_i,
  input  logic                    destroyable_block_i,
  output logic                    bullet_collide_o,
  output logic                    bullet_active_o,
  output logic                    bullet_enable_o,
  output logic [COLOR_BITS/3-1:0] bullet_red_o,
  output logic [COLOR_BITS/3-1:0] bullet_green_o,
  output logic [COLOR_BITS/3-1:0] bullet_blue_o
);

  localparam int         CH       = COLOR_BITS / 3;
  localparam logic [10:0] MAX_POS = 11'(1023 - BULLET_SIZE);
  localparam logic [10:0] STEP    = 11'(SPEED);
  localparam logic [9:0]  BOX_END = 10'(BULLET_SIZE - 1);
  localparam int          CD_W    = $clog2(COOLDOWN_FRAMES + 1);

  bullet_state_e state_q, state_d;
  logic [9:0]    bx_q, bx_d, by_q, by_d;
  dir_e          dir_q, dir_d;
  logic          hit_q, hit_d;
  logic          hit_destr_q, hit_destr_d;  // hit tile was a live brick
  logic          pulsed_q, pulsed_d;        // erode pulse already sent this REPORT
  logic          collide;

  logic            fire_edge;
  logic            accept;
  logic [CD_W-1:0] cooldown_cnt;
  logic            in_box;
  logic [10:0]     nx, ny;
  logic            oob;

  pos_edge_detect u_fire_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sig_i  (fire_i),
    .edge_o (fire_edge)
  );

`ifdef BULLET_COOLDOWN_EN
  logic [CD_W-1:0] cd_q;

  // Only the two normal return paths reach IDLE through state_d; reset is
  // handled in the register and clears the counter instead.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                                cd_q <= '0;
    else if (state_q != IDLE && state_d == IDLE) cd_q <= CD_W'(COOLDOWN_FRAMES);
    else if (frame_start_i && cd_q != '0)       cd_q <= cd_q - 1'b1;
  end

  assign cooldown_cnt = cd_q;
`else
  assign cooldown_cnt = '0;
`endif

  assign accept = fire_edge && (cooldown_cnt == '0);

  // Bounds never overflow: bx/by are held at or below 1023-BULLET_SIZE.
  assign in_box = display_enable_i &&
                  (hpos_i >= bx_q) && (hpos_i <= bx_q + BOX_END) &&
                  (vpos_i >= by_q) && (vpos_i <= by_q + BOX_END);

  // Candidate step, one bit wider so underflow/overflow is visible.
  always_comb begin
    nx  = {1'b0, bx_q};
    ny  = {1'b0, by_q};
    oob = 1'b0;
    unique case (dir_q)
      UP:    begin oob = ny < STEP; ny = ny - STEP; end
      RIGHT: begin nx  = nx + STEP; oob = nx > MAX_POS; end
      DOWN:  begin ny  = ny + STEP; oob = ny > MAX_POS; end
      LEFT:  begin oob = nx < STEP; nx = nx - STEP; end
      default: ;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    bx_d        = bx_q;
    by_d        = by_q;
    dir_d       = dir_q;
    hit_d       = hit_q;
    hit_destr_d = hit_destr_q;
    pulsed_d    = pulsed_q;
    collide     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          bx_d        = tank_x_i;
          by_d        = tank_y_i;
          dir_d       = dir_e'(tank_dir_i);
          hit_d       = 1'b0;
          hit_destr_d = 1'b0;
          pulsed_d    = 1'b0;
          state_d     = FLY;
        end
      end
      FLY: begin
        if (in_box && all_hard_block_i) begin
          hit_d = 1'b1;
          if (destroyable_block_i) hit_destr_d = 1'b1;
        end
        // hit_d already includes this clock's sample, so a hit on the
        // frame_start pixel still wins over the step.
        if (frame_start_i) begin
          if (hit_d)    state_d = REPORT;
          else if (oob) state_d = IDLE;
          else begin
            bx_d = nx[9:0];
            by_d = ny[9:0];
          end
        end
      end
      REPORT: begin
        if (in_box && destroyable_block_i && hit_destr_q && !pulsed_q) begin
          collide  = 1'b1;
          pulsed_d = 1'b1;
        end
        if (frame_start_i) begin
          state_d     = IDLE;
          hit_d       = 1'b0;
          hit_destr_d = 1'b0;
          pulsed_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge (synchronous), and clears every
  // control register so the first post-reset clock starts from IDLE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      bx_q        <= '0;
      by_q        <= '0;
      dir_q       <= UP;
      hit_q       <= 1'b0;
      hit_destr_q <= 1'b0;
      pulsed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      dir_q       <= dir_d;
      hit_q       <= hit_d;
      hit_destr_q <= hit_destr_d;
      pulsed_q    <= pulsed_d;
    end
  end

  // Gating with rst_ni kills a pending pulse in the reset clock itself.
  assign bullet_collide_o = collide && rst_ni;
  assign bullet_active_o  = (state_q != IDLE);
  assign bullet_enable_o  = in_box && (state_q == FLY);

  // BULLET_COLOR is packed {blue, green, red}.
  assign bullet_red_o   = bullet_enable_o ? BULLET_COLOR[CH-1:0]      : '0;
  assign bullet_green_o = bullet_enable_o ? BULLET_COLOR[2*CH-1:CH]   : '0;
  assign bullet_blue_o  = bullet_enable_o ? BULLET_COLOR[3*CH-1:2*CH] : '0;

endmodule

// File: tb/tb_bullet_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bullet_ctrl
//  Drives a compressed raster (individual pixels plus frame_start pulses) into
//  bullet_ctrl and compares collide/active/enable/colour against expectations.
// -----------------------------------------------------------------------------
module tb_bullet_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni, frame_start, display_enable, fire;
  logic [9:0] hpos, vpos, tank_x, tank_y;
  logic [1:0] tank_dir;
  logic       all_hard, destroyable;
  logic       collide, active, enable;
  logic [7:0] red, green, blue;

  always #5 clk = ~clk;

  bullet_ctrl dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .frame_start_i       (frame_start),
    .display_enable_i    (display_enable),
    .hpos_i              (hpos),
    .vpos_i              (vpos),
    .fire_i              (fire),
    .tank_x_i            (tank_x),
    .tank_y_i            (tank_y),
    .tank_dir_i          (tank_dir),
    .all_hard_block_i    (all_hard),
    .destroyable_block_i (destroyable),
    .bullet_collide_o    (collide),
    .bullet_active_o     (active),
    .bullet_enable_o     (enable),
    .bullet_red_o        (red),
    .bullet_green_o      (green),
    .bullet_blue_o       (blue)
  );

  typedef struct {
    string      tag;
    logic       rst, fs, de;
    logic [9:0] h, v;
    logic       fire;
    logic [9:0] tx, ty;
    logic [1:0] td;
    logic       hard, destr;
    logic       c, a, e;   // expected collide, active, enable
  } vec_t;

  typedef struct {
    string tag;
    logic  c, a, e;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Launch inputs applied by the vector builders.
  logic       g_fire = 1'b0;
  logic [9:0] g_tx = '0, g_ty = '0;
  logic [1:0] g_td = '0;

  function automatic vec_t pix(string tag, int h, int v, bit de, bit hard,
                               bit destr, bit c, bit a, bit e);
    vec_t r;
    r.tag = tag;  r.rst = 1'b1; r.fs = 1'b0; r.de = de;
    r.h = 10'(h); r.v = 10'(v);
    r.fire = g_fire; r.tx = g_tx; r.ty = g_ty; r.td = g_td;
    r.hard = hard; r.destr = destr;
    r.c = c; r.a = a; r.e = e;
    return r;
  endfunction

  function automatic vec_t frm(string tag, bit a);
    vec_t r = pix(tag, 0, 0, 0, 0, 0, 0, a, 0);
    r.fs = 1'b1;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst_ni = v.rst; frame_start = v.fs; display_enable = v.de;
    hpos = v.h; vpos = v.v; fire = v.fire;
    tank_x = v.tx; tank_y = v.ty; tank_dir = v.td;
    all_hard = v.hard; destroyable = v.destr;
  endtask

  // Outputs are combinational in the current clock, so they are sampled
  // mid-cycle after the inputs settle.
  task automatic compare_out();
    exp_t x;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard: queue empty, expected an entry");
    end else begin
      n_checks--;
      x = exp_q.pop_front();
      check({x.tag, ":collide"}, 32'(collide), 32'(x.c));
      check({x.tag, ":active"},  32'(active),  32'(x.a));
      check({x.tag, ":enable"},  32'(enable),  32'(x.e));
      check({x.tag, ":rgb"}, {8'h0, blue, green, red},
            x.e ? 32'h00FFFFFF : 32'h0);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t x;
    drive(v);
    x.tag = v.tag; x.c = v.c; x.a = v.a; x.e = v.e;
    exp_q.push_back(x);
    #1;
    compare_out();
  endtask

  // Release fire, then present a new launch position with a fire edge.
  task automatic launch(string tag, int x, int y, int d);
    g_fire = 1'b0;
    step(pix({tag, "_rel"}, 0, 0, 0, 0, 0, 0, 0, 0));
    g_fire = 1'b1; g_tx = 10'(x); g_ty = 10'(y); g_td = 2'(d);
    step(pix({tag, "_fire"}, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t r;

    // Reset: first clock only establishes state, the second is checked.
    r = pix("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    r.rst = 1'b0;
    drive(r);
    step(r);

    // Open-air flight RIGHT from (100,200), then a brick hit.
    g_fire = 1'b1; g_tx = 10'd100; g_ty = 10'd200; g_td = 2'd1;
    tbl.push_back(pix("t1_launch",   0,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(pix("t1_wait",     0,   0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(pix("t1_pre",    100, 200, 1, 0, 0, 0, 1, 1));
    tbl.push_back(frm("t1_f1", 1));
    tbl.push_back(frm("t1_f2", 1));
    tbl.push_back(frm("t1_f3", 1));
    tbl.push_back(pix("t1_tl",     106, 200, 1, 0, 0, 0, 1, 1));
    tbl.push_back(pix("t1_br",     109, 203, 1, 0, 0, 0, 1, 1));
    tbl.push_back(pix("t1_out_r",  110, 200, 1, 0, 0, 0, 1, 0));
    tbl.push_back(pix("t1_out_l",  105, 201, 1, 0, 0, 0, 1, 0));
    tbl.push_back(pix("t1_out_b",  106, 204, 1, 0, 0, 0, 1, 0));
    tbl.push_back(pix("t1_out_t",  108, 199, 1, 0, 0, 0, 1, 0));
    tbl.push_back(pix("t1_blank",  107, 202, 0, 0, 0, 0, 1, 0));
    tbl.push_back(pix("t2_hit",    107, 201, 1, 1, 1, 0, 1, 1));
    tbl.push_back(pix("t2_far",    150, 150, 1, 1, 1, 0, 1, 0));
    tbl.push_back(frm("t2_f_rep", 1));
    tbl.push_back(pix("t2_dead",   106, 200, 1, 1, 0, 0, 1, 0));
    tbl.push_back(pix("t2_pulse",  107, 200, 1, 1, 1, 1, 1, 0));
    tbl.push_back(pix("t2_once",   108, 200, 1, 1, 1, 0, 1, 0));
    tbl.push_back(frm("t2_f_idle", 1));
    tbl.push_back(pix("t2_idle",     0,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(pix("t2_held",     5,   5, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Wall hit going UP: REPORT for one frame, no pulse even on a brick.
    launch("t3", 300, 300, 0);
    step(pix("t3_wall",   301, 301, 1, 1, 0, 0, 1, 1));
    step(frm("t3_f_rep", 1));
    step(pix("t3_np1",    301, 301, 1, 1, 1, 0, 1, 0));
    step(pix("t3_np2",    300, 300, 1, 1, 1, 0, 1, 0));
    step(frm("t3_f_idle", 1));
    step(pix("t3_idle",     0,   0, 0, 0, 0, 0, 0, 0));

    // Hit sampled on the frame_start pixel itself wins over the step.
    launch("t7", 0, 0, 2);
    r = frm("t7_fs_hit", 1);
    r.de = 1'b1; r.hard = 1'b1; r.destr = 1'b1; r.e = 1'b1;
    step(r);
    step(pix("t7_pulse",    1, 1, 1, 1, 1, 1, 1, 0));
    step(frm("t7_f_idle", 1));
    step(pix("t7_idle",     0, 0, 0, 0, 0, 0, 0, 0));

    // LEFT from bx=1: out of bounds, no pulse; held fire does not relaunch.
    launch("t4", 1, 50, 3);
    step(pix("t4_fly",      0,  50, 1, 1, 1, 0, 1, 0));
    step(frm("t4_f_oob", 1));
    step(pix("t4_idle",     1,  50, 1, 1, 1, 0, 0, 0));
    step(frm("t4_f_held", 0));
    step(pix("t4_held",     2,  51, 1, 0, 0, 0, 0, 0));

    // RIGHT edge: 1017 -> 1019 is legal, 1021 is out of bounds.
    launch("t8", 1017, 10, 1);
    step(frm("t8_f1", 1));
    step(pix("t8_edge",  1022, 13, 1, 0, 0, 0, 1, 1));
    step(pix("t8_left",  1018, 10, 1, 0, 0, 0, 1, 0));
    step(frm("t8_f_oob", 1));
    step(pix("t8_idle",  1020, 11, 1, 0, 0, 0, 0, 0));

    // Reset for one clock in REPORT before the pulse pixel.
    launch("t5", 400, 400, 1);
    g_fire = 1'b0;
    step(pix("t5_hit",    401, 401, 1, 1, 1, 0, 1, 1));
    step(frm("t5_f_rep", 1));
    r = pix("t5_rst",     400, 400, 1, 1, 1, 0, 1, 0);
    r.rst = 1'b0;
    step(r);
    step(pix("t5_after",  401, 400, 1, 1, 1, 0, 0, 0));
    step(pix("t5_after2", 402, 402, 1, 1, 1, 0, 0, 0));
    step(frm("t5_f", 0));
    step(pix("t5_idle",     0,   0, 0, 0, 0, 0, 0, 0));

`ifdef BULLET_COOLDOWN_EN
    // Refire lockout: edges at 10 and 29 frames ignored, 30 launches.
    launch("t6", 1, 60, 3);
    g_fire = 1'b0;
    step(pix("t6_fly",      0, 0, 0, 0, 0, 0, 1, 0));
    step(frm("t6_f_oob", 1));
    for (int i = 1; i <= 30; i++) begin
      step(frm("t6_frame", 0));
      if (i == 10 || i == 29) begin
        g_fire = 1'b1;
        step(pix("t6_edge_ign", 0, 0, 0, 0, 0, 0, 0, 0));
        g_fire = 1'b0;
        step(pix("t6_still",    0, 0, 0, 0, 0, 0, 0, 0));
      end
    end
    g_fire = 1'b1;
    step(pix("t6_edge_ok", 0, 0, 0, 0, 0, 0, 0, 0));
    step(pix("t6_launched", 0, 0, 0, 0, 0, 0, 1, 0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
